// File: rtl/multiword_add_pkg.sv
// ----------------------------------------------------------------------------
// multiword_add_pkg
//   Shared types and helpers for the word-serial multi-precision adder.
//   - state_t        : operand-tracking FSM states (IDLE between operands,
//                      BUSY while the carry of a partial operand is held)
//   - beat_cnt_width : width of the per-operand beat counter for a given
//                      beat limit (wide enough to hold 0..max_beats)
// ----------------------------------------------------------------------------
package multiword_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Beat counter width for the default configuration of the stage.
    localparam int unsigned MAX_BEATS_DEFAULT = 4;
    localparam int unsigned BEAT_CNT_W_DEFAULT = $clog2(MAX_BEATS_DEFAULT + 1);

    // Counter width able to represent 0..max_beats; never narrower than 1 bit.
    function automatic int beat_cnt_width(input int max_beats);
        int w;
        w = $clog2(max_beats + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/word_add_cell.sv
// ----------------------------------------------------------------------------
// word_add_cell
//   Combinational N-bit adder with carry in and carry out.
//   Ports:
//     a, b  in  N   addend words
//     cin   in  1   carry in
//     sum   out N   low N bits of a + b + cin
//     cout  out 1   carry out of bit N-1
// ----------------------------------------------------------------------------
module word_add_cell #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // Zero-extend everything to N+1 bits so the carry lands in the top bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// ----------------------------------------------------------------------------
// multiword_add_seq
//   Streaming multi-precision adder stage. Operand pairs arrive one N-bit word
//   per beat, least-significant word first; the carry is chained between beats
//   and one registered sum word is emitted per beat (1-cycle latency, full
//   throughput). A beat limit (MAX_BEATS) forces the end of an operand that
//   never signals in_last and flags it on out_err.
//
//   Optional feature macro: OVERFLOW_DETECT_EN
//     defined   -> out_ovf reports signed overflow of the final word
//     undefined -> out_ovf is tied to 0
//
//   Ports:
//     clk        in   1   clock, rising edge
//     rst        in   1   asynchronous active-high reset
//     in_valid   in   1   operand beat valid
//     in_ready   out  1   stage can accept a beat
//     in_a       in   N   operand A word
//     in_b       in   N   operand B word
//     in_last    in   1   final (most-significant) word of the operand
//     out_valid  out  1   sum beat valid
//     out_ready  in   1   downstream accepts the sum beat
//     out_sum    out  N   sum word
//     out_last   out  1   final word of the result
//     out_carry  out  1   carry out of the final word (0 on non-last beats)
//     out_err    out  1   operand was cut at the beat limit (forced last)
//     out_ovf    out  1   signed overflow of the final word
// ----------------------------------------------------------------------------
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_last,
    output logic         out_carry,
    output logic         out_err,
    output logic         out_ovf
);

    localparam int CNT_W = beat_cnt_width(MAX_BEATS);
    // Counter value of the final permitted beat of an operand.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    // ------------------------------------------------------------------
    // State and output register slice
    // ------------------------------------------------------------------
    state_t          state_q;
    logic            carry_q;
    logic [CNT_W-1:0] beat_cnt_q;

    logic            out_valid_q;
    logic [N-1:0]    out_sum_q;
    logic            out_last_q;
    logic            out_carry_q;
    logic            out_err_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic            xfer;
    logic            last_eff;
    logic            cin;
    logic [N-1:0]    sum_w;
    logic            cout_w;
    logic [CNT_W-1:0] beat_cnt_d;

    // The slice can take a new beat when it is empty or is being drained
    // this same cycle, which gives one beat per cycle under no backpressure.
    assign in_ready = !out_valid_q | out_ready;
    assign xfer     = in_valid & in_ready;

    // An operand ends either on in_last or when the beat limit is reached.
    assign last_eff = in_last | (beat_cnt_q == LAST_CNT);

    // Carry is only meaningful mid-operand; the first word always adds with 0.
    assign cin = (state_q == BUSY) & carry_q;

    assign beat_cnt_d = (state_q == IDLE) ? CNT_W'(1) : beat_cnt_q + CNT_W'(1);

    word_add_cell #(
        .N (N)
    ) u_add (
        .a    (in_a),
        .b    (in_b),
        .cin  (cin),
        .sum  (sum_w),
        .cout (cout_w)
    );

`ifdef OVERFLOW_DETECT_EN
    logic out_ovf_q;
    logic ovf_d;

    // Signed overflow: both addends share a sign and the result sign differs.
    assign ovf_d = last_eff & (in_a[N-1] == in_b[N-1]) & (sum_w[N-1] != in_a[N-1]);
    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM, beat counter, carry chain and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= sum_w;
                out_last_q  <= last_eff;
                out_carry_q <= last_eff & cout_w;
                // Error only when the limit, not the source, ended the operand.
                out_err_q   <= last_eff & !in_last;
`ifdef OVERFLOW_DETECT_EN
                out_ovf_q   <= ovf_d;
`endif
                if (last_eff) begin
                    state_q    <= IDLE;
                    carry_q    <= 1'b0;
                    beat_cnt_q <= '0;
                end else begin
                    state_q    <= BUSY;
                    carry_q    <= cout_w;
                    beat_cnt_q <= beat_cnt_d;
                end
            end else if (out_ready) begin
                // Beat consumed and nothing new to load; payload fields keep
                // their last value but are qualified by out_valid.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// ----------------------------------------------------------------------------
// tb_multiword_add_seq
//   Directed scenarios followed by randomized traffic with random backpressure.
//   The reference model collects whole operands, adds them as wide integers
//   and slices the result back into expected output words.
// ----------------------------------------------------------------------------
module tb_multiword_add_seq;

    localparam int N         = 8;
    localparam int MAX_BEATS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_last;
    logic         out_carry;
    logic         out_err;
    logic         out_ovf;

    multiword_add_seq #(
        .N         (N),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_carry (out_carry),
        .out_err   (out_err),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

`ifdef OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Observed output word packed as {valid, err, carry, last, sum}.
    function automatic logic [31:0] out_word();
        return {20'd0, out_valid, out_err, out_carry, out_last, out_sum};
    endfunction

    function automatic logic [31:0] exp_word(input logic [7:0] s, input logic last,
                                              input logic carry, input logic err);
        return {20'd0, 1'b1, err, carry, last, s};
    endfunction

    // Drive one beat with the sink ready; returns at posedge+1 so the
    // registered result is visible immediately.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic last);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole-operand wide arithmetic
    // ------------------------------------------------------------------
    typedef logic [11:0] beat_t; // {ovf, err, carry, last, sum}
    logic [7:0] ma[$];
    logic [7:0] mb[$];
    beat_t      exp_q[$];
    beat_t      obs_q[$];

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic last);
        logic [63:0] wa, wb, tot;
        int          k;
        logic [7:0]  s;
        logic        lst, cy, er, ov;
        ma.push_back(a);
        mb.push_back(b);
        if (last || ma.size() == MAX_BEATS) begin
            k  = ma.size();
            wa = '0;
            wb = '0;
            for (int i = 0; i < k; i++) begin
                wa[i*8 +: 8] = ma[i];
                wb[i*8 +: 8] = mb[i];
            end
            tot = wa + wb;
            for (int i = 0; i < k; i++) begin
                s   = tot[i*8 +: 8];
                lst = (i == k - 1);
                cy  = lst & tot[k*8];
                er  = lst & !last;
                ov  = OVF_EN & lst & (ma[i][7] == mb[i][7]) & (s[7] != ma[i][7]);
                exp_q.push_back({ov, er, cy, lst, s});
            end
            ma.delete();
            mb.delete();
        end
    endtask

    task automatic compare_ready();
        beat_t o, e;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check("rand_beat", {20'd0, o}, {20'd0, e});
        end
    endtask

    logic  hold_q = 1'b0;
    beat_t prev_w;
    bit    pend = 1'b0;

    task automatic sample();
        beat_t cur;
        cur = {out_ovf, out_err, out_carry, out_last, out_sum};
        if (hold_q) check("hold", {19'd0, out_valid, cur}, {19'd0, 1'b1, prev_w});
        hold_q = out_valid & !out_ready;
        prev_w = cur;
        if (out_valid && out_ready) obs_q.push_back(cur);
        pend = in_valid & !in_ready;
        if (in_valid && in_ready) model_accept(in_a, in_b, in_last);
        compare_ready();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out", {26'd0, out_valid, out_last, out_carry, out_err, out_ovf, 1'b0} | {24'd0, out_sum}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single beat with carry out
        beat(8'hFF, 8'h01, 1'b1);
        check("single", out_word(), exp_word(8'h00, 1'b1, 1'b1, 1'b0));

        // Carry chained across two beats
        beat(8'hFF, 8'h01, 1'b0);
        check("two_b0", out_word(), exp_word(8'h00, 1'b0, 1'b0, 1'b0));
        beat(8'h00, 8'h00, 1'b1);
        check("two_b1", out_word(), exp_word(8'h01, 1'b1, 1'b0, 1'b0));

        // Runaway operand forced to end at the beat limit
        for (int i = 0; i < MAX_BEATS; i++) begin
            beat(8'h01, 8'h01, 1'b0);
            check("runaway", out_word(),
                  exp_word(8'h02, i == MAX_BEATS - 1, 1'b0, i == MAX_BEATS - 1));
        end
        beat(8'h01, 8'h01, 1'b1);
        check("after_runaway", out_word(), exp_word(8'h02, 1'b1, 1'b0, 1'b0));

        // Backpressure: output held, input stalled, then released in order
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drained", {31'd0, out_valid}, 32'd0);
        in_a = 8'h10; in_b = 8'h20; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_first", out_word(), exp_word(8'h30, 1'b0, 1'b0, 1'b0));
        in_a = 8'h05; in_b = 8'h06; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", out_word(), exp_word(8'h30, 1'b0, 1'b0, 1'b0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second", out_word(), exp_word(8'h0B, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-operand
        beat(8'hFF, 8'h01, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst", {22'd0, out_valid, out_last, out_carry, out_err, out_sum}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        beat(8'h00, 8'h00, 1'b1);
        check("post_rst", out_word(), exp_word(8'h00, 1'b1, 1'b0, 1'b0));

        // Signed overflow flag
        beat(8'h7F, 8'h01, 1'b1);
        check("ovf_sum", {24'd0, out_sum}, 32'h80);
        check("ovf_pos", {31'd0, out_ovf}, {31'd0, OVF_EN});
        beat(8'hFF, 8'h01, 1'b1);
        check("ovf_none", {31'd0, out_ovf}, 32'd0);

        // Let the last directed beat drain before randomized traffic
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_last  = ($urandom_range(0, 4) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            sample();
        end

        // Close any open operand, then drain with bounded waits
        begin
            bit done = 1'b0;
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
                #1;
                done = in_ready;
                sample();
            end
            check("drain_accept", {31'd0, done}, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            sample();
        end
        check("drain_obs", obs_q.size(), 32'd0);
        check("drain_exp", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
